// File: rtl/hs_buf_pkg.sv
// Shared types and helpers for the four-phase handshake FIFO buffer.
package hs_buf_pkg;

  typedef enum logic {IN_IDLE, IN_ACK} inState_e;

  typedef enum logic [1:0] {OUT_IDLE, OUT_SETUP, OUT_REQ, OUT_WAIT} outState_e;

  // Bits needed to hold an occupancy value from 0 to depth inclusive.
  function automatic int unsigned countWidth(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/hs_sync.sv
// N-stage 1-bit synchroniser with synchronous active-low reset; zero stages is a wire.
module hs_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  generate
    if (STAGES == 0) begin : gPass
      logic unusedClkRst;
      assign unusedClkRst = clk ^ rst_n;
      assign q = d;
    end else begin : gFlops
      logic [STAGES-1:0] stages;

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          stages <= '0;
        end else begin
          stages[0] <= d;
          for (int unsigned i = 1; i < STAGES; i++) begin
            stages[i] <= stages[i-1];
          end
        end
      end

      assign q = stages[STAGES-1];
    end
  endgenerate

endmodule

// File: rtl/hs_fifo_buf.sv
// DEPTH-entry buffer between a four-phase Sender and a four-phase Receiver;
// the two sides run independently so accepting and delivering can overlap.
module hs_fifo_buf
  import hs_buf_pkg::*;
#(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned SYNC_STAGES = 0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         StoB_REQ,
  input  logic [WIDTH-1:0]             DI,
  output logic                         BtoS_ACK,
  output logic                         BtoR_REQ,
  output logic [WIDTH-1:0]             DO,
  input  logic                         RtoB_ACK,
  output logic [countWidth(DEPTH)-1:0] count,
  output logic                         full,
  output logic                         empty
);

  localparam int unsigned CW = countWidth(DEPTH);
  localparam int unsigned PW = $clog2(DEPTH);

  logic             reqS;
  logic             ackS;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wptr;
  logic [PW-1:0]    rptr;

  inState_e  inState,  inNext;
  outState_e outState, outNext;
  logic      ackNext, reqNext, push, pop, loadDo;
  logic [CW-1:0] countNext;

  hs_sync #(.STAGES(SYNC_STAGES)) uReqSync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (StoB_REQ),
    .q     (reqS)
  );

  hs_sync #(.STAGES(SYNC_STAGES)) uAckSync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (RtoB_ACK),
    .q     (ackS)
  );

  // Sender side: accept one word per request, stall while the buffer is full.
  always_comb begin
    inNext  = inState;
    ackNext = BtoS_ACK;
    push    = 1'b0;
    case (inState)
      IN_IDLE: begin
        if (reqS && !full) begin
          push    = 1'b1;
          ackNext = 1'b1;
          inNext  = IN_ACK;
        end
      end
      IN_ACK: begin
        if (!reqS) begin
          ackNext = 1'b0;
          inNext  = IN_IDLE;
        end
      end
      default: inNext = IN_IDLE;
    endcase
  end

  // Receiver side: present DO a full cycle before raising BtoR_REQ.
  always_comb begin
    outNext = outState;
    reqNext = BtoR_REQ;
    pop     = 1'b0;
    loadDo  = 1'b0;
    case (outState)
      OUT_IDLE: begin
        if (!empty && !ackS) begin
          loadDo  = 1'b1;
          outNext = OUT_SETUP;
        end
      end
      OUT_SETUP: begin
        reqNext = 1'b1;
        outNext = OUT_REQ;
      end
      OUT_REQ: begin
        if (ackS) begin
          reqNext = 1'b0;
          pop     = 1'b1;
          outNext = OUT_WAIT;
        end
      end
      OUT_WAIT: begin
        if (!ackS) outNext = OUT_IDLE;
      end
      default: outNext = OUT_IDLE;
    endcase
  end

  always_comb begin
    countNext = count + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      inState  <= IN_IDLE;
      outState <= OUT_IDLE;
      BtoS_ACK <= 1'b0;
      BtoR_REQ <= 1'b0;
      DO       <= '0;
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      full     <= 1'b0;
      empty    <= 1'b1;
    end else begin
      inState  <= inNext;
      outState <= outNext;
      BtoS_ACK <= ackNext;
      BtoR_REQ <= reqNext;
      if (loadDo) DO <= mem[rptr];
      if (push) wptr <= wptr + PW'(1);
      if (pop) rptr <= rptr + PW'(1);
      count <= countNext;
      full  <= (countNext == CW'(DEPTH));
      empty <= (countNext == '0);
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (push && rst_n) mem[wptr] <= DI;
  end

endmodule

// File: tb/tb_hs_fifo_buf.sv
// Randomised and directed bench for hs_fifo_buf against a queue-based handshake model.
module tb_hs_fifo_buf;

  localparam int unsigned D0 = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sReq;
  logic [31:0] di;
  logic        sAck;
  logic        rReq;
  logic [31:0] dOut;
  logic        rAck;
  logic [2:0]  cnt;
  logic        full;
  logic        empty;

  logic        s2Req;
  logic [7:0]  di2;
  logic        ack2;
  logic        req2;
  logic [7:0]  do2;
  logic        r2Ack;
  logic [2:0]  count2;
  logic        full2;
  logic        empty2;

  always #5 clk = ~clk;

  hs_fifo_buf #(.WIDTH(32), .DEPTH(4), .SYNC_STAGES(0)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .StoB_REQ (sReq),
    .DI       (di),
    .BtoS_ACK (sAck),
    .BtoR_REQ (rReq),
    .DO       (dOut),
    .RtoB_ACK (rAck),
    .count    (cnt),
    .full     (full),
    .empty    (empty)
  );

  hs_fifo_buf #(.WIDTH(8), .DEPTH(4), .SYNC_STAGES(2)) dutSync (
    .clk      (clk),
    .rst_n    (rst_n),
    .StoB_REQ (s2Req),
    .DI       (di2),
    .BtoS_ACK (ack2),
    .BtoR_REQ (req2),
    .DO       (do2),
    .RtoB_ACK (r2Ack),
    .count    (count2),
    .full     (full2),
    .empty    (empty2)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // Behavioural model: the buffer is a queue, each handshake a few flags.
  logic [31:0] mq[$];
  bit          mAck, mReq, mLoaded, mWaitLow;
  logic [31:0] mDo;
  bit          chkEn = 1'b0;

  always @(posedge clk) begin
    int sz;
    bit doPush, doPop;
    if (!rst_n) begin
      mq.delete();
      mAck = 1'b0; mReq = 1'b0; mLoaded = 1'b0; mWaitLow = 1'b0; mDo = '0;
    end else begin
      sz     = mq.size();
      doPush = sReq && !mAck && (sz < int'(D0));
      doPop  = mReq && rAck;
      if (doPush) mAck = 1'b1;
      else if (mAck && !sReq) mAck = 1'b0;
      if (mReq) begin
        if (rAck) begin mReq = 1'b0; mWaitLow = 1'b1; end
      end else if (mLoaded) begin
        mReq = 1'b1; mLoaded = 1'b0;
      end else if (mWaitLow) begin
        if (!rAck) mWaitLow = 1'b0;
      end else if (sz > 0 && !rAck) begin
        mDo = mq[0]; mLoaded = 1'b1;
      end
      if (doPush) mq.push_back(di);
      if (doPop) void'(mq.pop_front());
    end
  end

  logic        prevRReq = 1'b0;
  logic [31:0] prevDo = '0;
  logic [2:0]  maxCnt = '0;

  always @(negedge clk) begin
    if (chkEn) begin
      check("cycle {ack,req,do,count,full,empty}",
            {25'b0, sAck, rReq, dOut, cnt, full, empty},
            {25'b0, mAck, mReq, mDo, 3'(mq.size()), mq.size() == int'(D0), mq.size() == 0});
      if (rReq && !prevRReq) check("do_setup", 64'(dOut), 64'(prevDo));
      if (cnt > maxCnt) maxCnt = cnt;
    end
    prevRReq = rReq;
    prevDo   = dOut;
  end

  logic        pSReq = 1'b0;
  logic [31:0] pDi = '0;
  logic        pRAck = 1'b0;

  always @(posedge clk) begin
    if (rst_n === 1'b1) begin
      assert (!(sReq && pSReq && di !== pDi)) else $error("protocol: DI changed under StoB_REQ");
      assert (!(rAck && !pRAck && !rReq)) else $error("protocol: RtoB_ACK rose without BtoR_REQ");
    end
    pSReq = sReq;
    pDi   = di;
    pRAck = rAck;
  end

  logic [31:0] sent[$];
  logic [31:0] got[$];

  task automatic waitSAck(input logic lvl, input string tag);
    int n = 0;
    while (sAck !== lvl && n < 500) begin @(negedge clk); n++; end
    if (sAck !== lvl) begin
      vectors++; miscompares++;
      $display("FAIL %s timeout: BtoS_ACK=%b, required %b", tag, sAck, lvl);
    end
  endtask

  task automatic waitRReq(input logic lvl, input string tag);
    int n = 0;
    while (rReq !== lvl && n < 500) begin @(negedge clk); n++; end
    if (rReq !== lvl) begin
      vectors++; miscompares++;
      $display("FAIL %s timeout: BtoR_REQ=%b, required %b", tag, rReq, lvl);
    end
  endtask

  task automatic sendWord(input logic [31:0] w, input int gap);
    repeat (gap) @(negedge clk);
    di = w; sReq = 1'b1; sent.push_back(w);
    @(negedge clk); waitSAck(1'b1, "send_ack");
    sReq = 1'b0;
    @(negedge clk); waitSAck(1'b0, "send_release");
  endtask

  task automatic recvWord(input int dly);
    waitRReq(1'b1, "recv_req");
    repeat (dly) @(negedge clk);
    got.push_back(dOut); rAck = 1'b1;
    @(negedge clk); waitRReq(1'b0, "recv_drop");
    rAck = 1'b0;
    @(negedge clk);
  endtask

  task automatic sendN(input logic [31:0] base, input int n, input int maxGap);
    for (int i = 0; i < n; i++) sendWord(base + 32'(i), int'($urandom_range(maxGap, 0)));
  endtask

  task automatic recvN(input int n, input int minD, input int maxD);
    for (int i = 0; i < n; i++) recvWord(int'($urandom_range(maxD, minD)));
  endtask

  task automatic checkOrder(input string tag);
    check({tag, "_len"}, 64'(got.size()), 64'(sent.size()));
    for (int i = 0; i < sent.size(); i++) begin
      if (i < got.size()) check(tag, 64'(got[i]), 64'(sent[i]));
    end
    sent.delete(); got.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_n = 1'b0; sReq = 1'b1; di = 32'h11; rAck = 1'b0;
    s2Req = 1'b0; di2 = '0; r2Ack = 1'b0;
    @(negedge clk); @(negedge clk);

    // Reset with a request already pending.
    check("rst_ack", 64'(sAck), 64'(0));
    check("rst_req", 64'(rReq), 64'(0));
    check("rst_count", 64'(cnt), 64'(0));
    check("rst_empty", 64'(empty), 64'(1));
    check("rst_full", 64'(full), 64'(0));
    check("rst_do", 64'(dOut), 64'(0));
    chkEn = 1'b1;
    rst_n = 1'b1;
    @(negedge clk);
    check("t1_ack", 64'(sAck), 64'(1));
    check("t1_count", 64'(cnt), 64'(1));
    sent.push_back(32'h11);
    sReq = 1'b0;
    @(negedge clk); waitSAck(1'b0, "t1_release");
    recvWord(1);
    checkOrder("t1_order");

    // Streaming with a fixed-latency receiver, then fully random timing.
    fork
      sendN(32'd0, 100, 3);
      recvN(100, 2, 2);
    join
    checkOrder("t2_order");
    fork
      sendN(32'd1000, 60, 3);
      recvN(60, 0, 5);
    join
    checkOrder("rand_order");

    // Fill to full with an idle receiver, then free one slot.
    for (int i = 0; i < 4; i++) sendWord(32'd300 + 32'(i), 0);
    di = 32'd304; sReq = 1'b1; sent.push_back(32'd304);
    repeat (4) @(negedge clk);
    check("t3_stall_ack", 64'(sAck), 64'(0));
    check("t3_full", 64'(full), 64'(1));
    check("t3_count", 64'(cnt), 64'(4));
    check("t3_req", 64'(rReq), 64'(1));
    check("t3_head", 64'(dOut), 64'(300));
    got.push_back(dOut); rAck = 1'b1;
    @(negedge clk);
    check("t3_pop_count", 64'(cnt), 64'(3));
    check("t3_pop_stall", 64'(sAck), 64'(0));
    @(negedge clk);
    check("t3_accept", 64'(sAck), 64'(1));
    check("t3_refill", 64'(cnt), 64'(4));
    sReq = 1'b0; rAck = 1'b0;
    @(negedge clk); waitSAck(1'b0, "t3_release");
    recvN(4, 1, 1);
    checkOrder("t3_order");

    // Simultaneous push and pop at count 2, then wrap the pointers.
    sendWord(32'd400, 0);
    sendWord(32'd401, 0);
    repeat (3) @(negedge clk);
    check("t4_pre_count", 64'(cnt), 64'(2));
    check("t4_pre_req", 64'(rReq), 64'(1));
    got.push_back(dOut); rAck = 1'b1;
    di = 32'd402; sReq = 1'b1; sent.push_back(32'd402);
    @(negedge clk);
    check("t4_count", 64'(cnt), 64'(2));
    check("t4_ack", 64'(sAck), 64'(1));
    check("t4_req", 64'(rReq), 64'(0));
    sReq = 1'b0; rAck = 1'b0;
    @(negedge clk); waitSAck(1'b0, "t4_release");
    fork
      sendN(32'd403, 7, 2);
      recvN(9, 0, 3);
    join
    checkOrder("t4_order");

    // Reset in the middle of a delivery.
    for (int i = 0; i < 3; i++) sendWord(32'd500 + 32'(i), 0);
    repeat (3) @(negedge clk);
    check("t5_pre_count", 64'(cnt), 64'(3));
    check("t5_pre_req", 64'(rReq), 64'(1));
    rst_n = 1'b0;
    @(negedge clk);
    check("t5_req", 64'(rReq), 64'(0));
    check("t5_ack", 64'(sAck), 64'(0));
    check("t5_count", 64'(cnt), 64'(0));
    check("t5_empty", 64'(empty), 64'(1));
    sent.delete(); got.delete();
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check("t5_no_stale", 64'(rReq), 64'(0));
    check("t5_still_empty", 64'(empty), 64'(1));
    check("t5_do", 64'(dOut), 64'(0));

    // Two-stage synchronised instance latencies.
    @(negedge clk);
    di2 = 8'hA5; s2Req = 1'b1;
    @(negedge clk); @(negedge clk);
    check("t6_ack_early", 64'(ack2), 64'(0));
    @(negedge clk);
    check("t6_ack", 64'(ack2), 64'(1));
    check("t6_count", 64'(count2), 64'(1));
    @(negedge clk);
    check("t6_req_setup", 64'(req2), 64'(0));
    check("t6_do", 64'(do2), 64'(8'hA5));
    @(negedge clk);
    check("t6_req", 64'(req2), 64'(1));
    check("t6_do_held", 64'(do2), 64'(8'hA5));
    s2Req = 1'b0; r2Ack = 1'b1;
    n = 0;
    while (req2 !== 1'b0 && n < 50) begin @(negedge clk); n++; end
    check("t6_req_drop", 64'(req2), 64'(0));
    r2Ack = 1'b0;
    n = 0;
    while ((count2 !== 3'd0 || ack2 !== 1'b0) && n < 50) begin @(negedge clk); n++; end
    check("t6_drained", 64'(count2), 64'(0));
    check("t6_empty", 64'(empty2), 64'(1));
    check("t6_ack_low", 64'(ack2), 64'(0));

    check("max_count", 64'(maxCnt), 64'(4));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
